// File: rtl/section_channel_scheduler_pkg.sv
// Shared encodings for the section channel scheduler: channel tags and FSM states.
package section_channel_scheduler_pkg;

   localparam logic TAG_L = 1'b0;
   localparam logic TAG_R = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_L = 2'd1,
      ST_GRANT_R = 2'd2
   } state_t;

endpackage

// File: rtl/section_channel_scheduler_tag_fifo.sv
// In-order FIFO of 1-bit channel tags, one entry per section in flight in the engine.
module section_tag_fifo #(
   parameter int depth = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic push_tag,
   input  logic pop,
   output logic head_tag,
   output logic full,
   output logic empty
);

   localparam int PW = (depth > 1) ? $clog2(depth) : 1;
   localparam int NW = $clog2(depth + 1);
   localparam logic [PW-1:0] LAST_SLOT = PW'(depth - 1);

   logic [depth-1:0] slots;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [NW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == NW'(depth));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_tag = slots[rd_ptr];

   // Pointer, storage and occupancy update; push and pop may happen in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slots  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            slots[wr_ptr] <= push_tag;
            wr_ptr        <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PW'(1);
         end
         count <= count + NW'(do_push) - NW'(do_pop);
      end
   end

endmodule

// File: rtl/section_channel_scheduler.sv
// Time-shares one section engine between left and right streams, one whole section per grant,
// and steers engine results back to per-channel level registers through a tag FIFO.
module section_channel_scheduler
   import section_channel_scheduler_pkg::*;
#(
   parameter int width        = 16,
   parameter int sample_count = 3,
   parameter int tag_depth    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             l_valid,
   output logic             l_ready,
   input  logic [width-1:0] l_value,
   input  logic             r_valid,
   output logic             r_ready,
   input  logic [width-1:0] r_value,
   output logic             eng_valid,
   input  logic             eng_ready,
   output logic [width-1:0] eng_value,
   input  logic             eng_res_valid,
   output logic             eng_res_ready,
   input  logic [width-1:0] eng_res_value,
   output logic [width-1:0] l_level,
   output logic             l_level_valid,
   output logic [width-1:0] r_level,
   output logic             r_level_valid,
   output logic             error
);

   localparam int CW = (sample_count > 1) ? $clog2(sample_count) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(sample_count - 1);

   state_t        state;
   logic [CW-1:0] beat_cnt;
   logic          last_grant;
   logic          tag_full;
   logic          tag_empty;
   logic          head_tag;
   logic          push;
   logic          push_tag;
   logic          pop;
   logic          beat;

   section_tag_fifo #(
      .depth(tag_depth)
   ) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .push_tag(push_tag),
      .pop     (pop),
      .head_tag(head_tag),
      .full    (tag_full),
      .empty   (tag_empty)
   );

   assign eng_res_ready = !tag_empty;
   assign pop           = eng_res_valid && !tag_empty;

   // Arbitration in IDLE: a lone requester wins, a tie goes to the channel not granted last time.
   always_comb begin
      push     = 1'b0;
      push_tag = TAG_L;
      if (state == ST_IDLE && !tag_full) begin
         if (l_valid && r_valid) begin
            push     = 1'b1;
            push_tag = (last_grant == TAG_L) ? TAG_R : TAG_L;
         end else if (l_valid) begin
            push     = 1'b1;
            push_tag = TAG_L;
         end else if (r_valid) begin
            push     = 1'b1;
            push_tag = TAG_R;
         end
      end
   end

   // Zero-latency pass-through of the granted channel to the engine.
   always_comb begin
      l_ready   = 1'b0;
      r_ready   = 1'b0;
      eng_valid = 1'b0;
      eng_value = '0;
      beat      = 1'b0;
      case (state)
         ST_GRANT_L: begin
            eng_valid = l_valid;
            eng_value = l_value;
            l_ready   = eng_ready;
            beat      = l_valid && eng_ready;
         end
         ST_GRANT_R: begin
            eng_valid = r_valid;
            eng_value = r_value;
            r_ready   = eng_ready;
            beat      = r_valid && eng_ready;
         end
         default: ;
      endcase
   end

   // Grant FSM: enter a grant from IDLE, count beats, return to IDLE after the last beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         beat_cnt   <= '0;
         last_grant <= TAG_R;
      end else begin
         case (state)
            ST_IDLE: begin
               if (push) begin
                  state      <= (push_tag == TAG_L) ? ST_GRANT_L : ST_GRANT_R;
                  beat_cnt   <= '0;
                  last_grant <= push_tag;
               end
            end
            ST_GRANT_L, ST_GRANT_R: begin
               if (beat) begin
                  if (beat_cnt == LAST_BEAT) begin
                     state <= ST_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Result steering: the head tag picks the level register; results with no tag raise a sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l_level       <= '0;
         r_level       <= '0;
         l_level_valid <= 1'b0;
         r_level_valid <= 1'b0;
         error         <= 1'b0;
      end else begin
         l_level_valid <= 1'b0;
         r_level_valid <= 1'b0;
         if (pop) begin
            if (head_tag == TAG_L) begin
               l_level       <= eng_res_value;
               l_level_valid <= 1'b1;
            end else begin
               r_level       <= eng_res_value;
               r_level_valid <= 1'b1;
            end
         end
         if (eng_res_valid && tag_empty) begin
            error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_section_channel_scheduler.sv
// Directed, table-driven bench for section_channel_scheduler (width 16, 3 samples, 2 tags).
module tb_section_channel_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        l_valid, l_ready, r_valid, r_ready;
   logic [15:0] l_value, r_value;
   logic        eng_valid, eng_ready, eng_res_valid, eng_res_ready;
   logic [15:0] eng_value, eng_res_value;
   logic [15:0] l_level, r_level;
   logic        l_level_valid, r_level_valid, error;

   int checks   = 0;
   int failures = 0;

   // One cycle of stimulus plus the outputs expected just before the next rising edge.
   // flags = {l_ready, r_ready, eng_valid, eng_res_ready, l_level_valid, r_level_valid, error}
   typedef struct {
      logic        rst_n;
      logic        lv;
      logic [15:0] lval;
      logic        rv;
      logic [15:0] rval;
      logic        er;
      logic        resv;
      logic [15:0] resval;
      logic [6:0]  flags;
      logic [15:0] evalue;
      logic [15:0] llev;
      logic [15:0] rlev;
   } row_t;

   row_t vecs[$];

   section_channel_scheduler #(
      .width(16),
      .sample_count(3),
      .tag_depth(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .l_valid      (l_valid),
      .l_ready      (l_ready),
      .l_value      (l_value),
      .r_valid      (r_valid),
      .r_ready      (r_ready),
      .r_value      (r_value),
      .eng_valid    (eng_valid),
      .eng_ready    (eng_ready),
      .eng_value    (eng_value),
      .eng_res_valid(eng_res_valid),
      .eng_res_ready(eng_res_ready),
      .eng_res_value(eng_res_value),
      .l_level      (l_level),
      .l_level_valid(l_level_valid),
      .r_level      (r_level),
      .r_level_valid(r_level_valid),
      .error        (error)
   );

   always #5 clk = ~clk;

   function automatic row_t mk(int rst_n, int lv, int lval, int rv, int rval, int er,
                               int resv, int resval, int flags, int evalue, int llev, int rlev);
      row_t r;
      r.rst_n  = rst_n[0];
      r.lv     = lv[0];
      r.lval   = 16'(lval);
      r.rv     = rv[0];
      r.rval   = 16'(rval);
      r.er     = er[0];
      r.resv   = resv[0];
      r.resval = 16'(resval);
      r.flags  = 7'(flags);
      r.evalue = 16'(evalue);
      r.llev   = 16'(llev);
      r.rlev   = 16'(rlev);
      return r;
   endfunction

   // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
   task automatic applyStimulus(int rst_n, int lv, int lval, int rv, int rval, int er,
                                int resv, int resval);
      @(negedge clk);
      reset         = rst_n[0];
      l_valid       = lv[0];
      l_value       = 16'(lval);
      r_valid       = rv[0];
      r_value       = 16'(rval);
      eng_ready     = er[0];
      eng_res_valid = resv[0];
      eng_res_value = 16'(resval);
      #1;
   endtask

   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      l_valid = 1'b0; l_value = '0; r_valid = 1'b0; r_value = '0;
      eng_ready = 1'b0; eng_res_valid = 1'b0; eng_res_value = '0;

      // Reset, then a left-only section answered with 3333.
      vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,       'b0000000, 0,       0,       0));
      vecs.push_back(mk(1, 1, 'h1111,  0, 0, 1, 0, 0,       'b0000000, 0,       0,       0));
      vecs.push_back(mk(1, 1, 'h1111,  0, 0, 1, 0, 0,       'b1011000, 'h1111,  0,       0));
      vecs.push_back(mk(1, 1, 'h4444,  0, 0, 1, 0, 0,       'b1011000, 'h4444,  0,       0));
      vecs.push_back(mk(1, 1, 'h2222,  0, 0, 1, 0, 0,       'b1011000, 'h2222,  0,       0));
      vecs.push_back(mk(1, 0, 0,       0, 0, 1, 1, 'h3333,  'b0001000, 0,       0,       0));
      vecs.push_back(mk(1, 0, 0,       0, 0, 1, 0, 0,       'b0000100, 0,       'h3333,  0));
      vecs.push_back(mk(1, 0, 0,       0, 0, 1, 0, 0,       'b0000000, 0,       'h3333,  0));
      // Reset, then both channels request together: L first, R after one IDLE cycle.
      vecs.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0,       'b0000000, 0,       0,       0));
      vecs.push_back(mk(1, 1, 'h6666,  1, 0, 1, 0, 0,       'b0000000, 0,       0,       0));
      vecs.push_back(mk(1, 1, 'h6666,  1, 0, 1, 0, 0,       'b1011000, 'h6666,  0,       0));
      vecs.push_back(mk(1, 1, 'h1111,  1, 0, 1, 0, 0,       'b1011000, 'h1111,  0,       0));
      vecs.push_back(mk(1, 1, 'h2222,  1, 0, 1, 0, 0,       'b1011000, 'h2222,  0,       0));
      vecs.push_back(mk(1, 0, 0,       1, 0, 1, 0, 0,       'b0001000, 0,       0,       0));
      vecs.push_back(mk(1, 0, 0,       1, 0, 1, 1, 'h5555,  'b0111000, 0,       0,       0));
      vecs.push_back(mk(1, 0, 0,       1, 0, 1, 0, 0,       'b0111100, 0,       'h5555,  0));
      vecs.push_back(mk(1, 0, 0,       1, 0, 1, 0, 0,       'b0111000, 0,       'h5555,  0));
      vecs.push_back(mk(1, 0, 0,       0, 0, 1, 1, 'h0000,  'b0001000, 0,       'h5555,  0));
      vecs.push_back(mk(1, 0, 0,       0, 0, 1, 0, 0,       'b0000010, 0,       'h5555,  0));
      vecs.push_back(mk(1, 0, 0,       0, 0, 1, 0, 0,       'b0000000, 0,       'h5555,  0));
      // Spurious result with nothing outstanding: sticky error, levels untouched.
      vecs.push_back(mk(1, 0, 0,       0, 0, 0, 1, 'h7777,  'b0000000, 0,       'h5555,  0));
      vecs.push_back(mk(1, 0, 0,       0, 0, 0, 1, 'h7777,  'b0000001, 0,       'h5555,  0));
      vecs.push_back(mk(1, 0, 0,       0, 0, 0, 0, 0,       'b0000001, 0,       'h5555,  0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst_n, vecs[i].lv, vecs[i].lval, vecs[i].rv, vecs[i].rval,
                       vecs[i].er, vecs[i].resv, vecs[i].resval);
         checkOutput($sformatf("vec%0d", i),
                     64'({l_ready, r_ready, eng_valid, eng_res_ready, l_level_valid,
                          r_level_valid, error, eng_value, l_level, r_level}),
                     64'({vecs[i].flags, vecs[i].evalue, vecs[i].llev, vecs[i].rlev}));
      end

      // Backpressure mid-burst with R also requesting: L stalls, keeps the grant, finishes at beat 3.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("bp_reset_error", 64'(error), 64'(0));
      applyStimulus(1, 1, 'hA001, 1, 'hB000, 1, 0, 0);
      checkOutput("bp_idle", 64'({l_ready, r_ready, eng_valid}), 64'(3'b000));
      applyStimulus(1, 1, 'hA001, 1, 'hB000, 1, 0, 0);
      checkOutput("bp_beat1", 64'({l_ready, r_ready, eng_valid}), 64'(3'b101));
      applyStimulus(1, 1, 'hA002, 1, 'hB000, 1, 0, 0);
      checkOutput("bp_beat2", 64'({l_ready, r_ready, eng_valid}), 64'(3'b101));
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 'hA003, 1, 'hB000, 0, 0, 0);
         checkOutput("bp_stall", 64'({l_ready, r_ready, eng_valid, eng_value}),
                     64'({3'b001, 16'hA003}));
      end
      applyStimulus(1, 1, 'hA003, 1, 'hB000, 1, 0, 0);
      checkOutput("bp_beat3", 64'({l_ready, r_ready, eng_valid}), 64'(3'b101));
      applyStimulus(1, 0, 0, 1, 'hB000, 1, 0, 0);
      checkOutput("bp_idle_after", 64'({l_ready, r_ready, eng_valid}), 64'(3'b000));

      // Tag FIFO full (L and R outstanding): a new request waits until one result pops.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 1, 'hB001, 1, 0, 0);
         checkOutput("full_rburst", 64'({l_ready, r_ready, eng_valid}), 64'(3'b011));
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 1, 'hC001, 0, 0, 1, 0, 0);
         checkOutput("full_hold", 64'({l_ready, r_ready, eng_valid, eng_res_ready}),
                     64'(4'b0001));
      end
      applyStimulus(1, 1, 'hC001, 0, 0, 1, 1, 'h0101);
      checkOutput("full_pop_cycle", 64'({l_ready, eng_valid, eng_res_ready}), 64'(3'b001));
      applyStimulus(1, 1, 'hC001, 0, 0, 1, 0, 0);
      checkOutput("full_pop_level", 64'({l_ready, l_level_valid, l_level}),
                  64'({1'b0, 1'b1, 16'h0101}));
      applyStimulus(1, 1, 'hC001, 0, 0, 1, 0, 0);
      checkOutput("full_granted", 64'({l_ready, eng_valid}), 64'(2'b11));

      // Reset after two left beats clears everything; the next burst is a full 3 beats, L first.
      applyStimulus(1, 1, 'hC002, 0, 0, 1, 0, 0);
      checkOutput("rst_beat2", 64'(l_ready), 64'(1));
      applyStimulus(0, 1, 'hC003, 1, 'hD000, 1, 0, 0);
      checkOutput("rst_clear", 64'({l_ready, r_ready, eng_valid, eng_res_ready, l_level_valid,
                                    r_level_valid, error, l_level, r_level}), 64'(0));
      applyStimulus(1, 1, 'hC010, 1, 'hD000, 1, 0, 0);
      checkOutput("rst_idle", 64'({l_ready, r_ready, eng_valid}), 64'(3'b000));
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 'hC010, 1, 'hD000, 1, 0, 0);
         checkOutput("rst_lburst", 64'({l_ready, r_ready, eng_valid}), 64'(3'b101));
      end
      applyStimulus(1, 1, 'hC010, 1, 'hD000, 1, 0, 0);
      checkOutput("rst_burst_len", 64'({l_ready, r_ready, eng_valid}), 64'(3'b000));
      applyStimulus(1, 1, 'hC010, 1, 'hD000, 1, 0, 0);
      checkOutput("rst_r_next", 64'({l_ready, r_ready, eng_valid, eng_value}),
                  64'({3'b011, 16'hD000}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/section_channel_scheduler.md
Name: section_channel_scheduler

Overview:
- Time-shares one section_difference engine between left and right sample streams at section granularity: each grant forwards exactly sample_count samples from one channel, so the engine's section state never mixes channels.
- A small in-order tag FIFO steers each engine result to a per-channel level register.
- Sits between the stereo sample splitter and the level-meter display logic.

Parameters:
- width, 16, sample and result bit width.
- sample_count, 3, samples per section (>=1); also the burst length of one grant.
- tag_depth, 2, maximum sections in flight inside the engine (power of two, >=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- l_valid  in  1  left sample valid.
- l_ready  out  1  left sample accepted.
- l_value  in  width  left sample.
- r_valid  in  1  right sample valid.
- r_ready  out  1  right sample accepted.
- r_value  in  width  right sample.
- eng_valid  out  1  sample valid to engine.
- eng_ready  in  1  engine accepts sample.
- eng_value  out  width  sample to engine.
- eng_res_valid  in  1  engine result valid.
- eng_res_ready  out  1  scheduler accepts result.
- eng_res_value  in  width  engine result (section difference).
- l_level  out  width  latest left section result, held.
- l_level_valid  out  1  one-cycle pulse when l_level updates.
- r_level  out  width  latest right section result, held.
- r_level_valid  out  1  one-cycle pulse when r_level updates.
- error  out  1  sticky flag: result received with no outstanding tag.

Behaviour:
- Reset (reset=0, async): state IDLE, beat counter 0, last_grant=R (left wins first tie), tag FIFO empty. l_level, r_level, both pulses and error are 0. The engine is reset by the same signal; a reset mid-burst discards the partial section.
- States: IDLE, GRANT_L, GRANT_R.
- IDLE:
  - Grants nothing; l_ready=r_ready=eng_valid=0.
  - If the tag FIFO is not full, move to GRANT_L if only l_valid is high, GRANT_R if only r_valid is high.
  - If both are high, grant the channel opposite last_grant.
  - On entry: push the channel tag, clear the beat counter, update last_grant.
  - If the tag FIFO is full, stay in IDLE.
- GRANT_x:
  - Combinational pass-through, zero latency: eng_valid=x_valid, eng_value=x_value, x_ready=eng_ready. The other channel's ready is 0.
  - A beat is x_valid and eng_ready in the same cycle; each beat increments the counter.
  - On beat sample_count-1, return to IDLE. IDLE always lasts one cycle, so back-to-back sections carry a 1-cycle gap.
  - A grant is never preempted: x_valid or eng_ready low only stalls it. The other channel's requests are ignored until the burst completes.
- Result path:
  - eng_res_ready = tag FIFO not empty.
  - On handshake, pop the head tag. Write eng_res_value into l_level or r_level on the following edge and pulse the matching *_level_valid for one cycle.
  - If eng_res_valid is high while the FIFO is empty: set error, drop the value, leave the levels unchanged.
- Tag push and pop in the same cycle are both honoured. Push is evaluated against the pre-pop occupancy, so full blocks the grant even if a pop occurs that cycle.
- Levels are stored as-is; the difference is treated as unsigned.

Decomposition:
- Shared package: channel tag encoding (TAG_L=0, TAG_R=1) and state encoding constants.
- One natural sub-module, section_tag_fifo: synchronous 1-bit FIFO of tag_depth entries with full/empty flags, on the same async active-low reset.

Test Plan:
- Left only: after reset, l_valid with 1111, 4444, 2222 (eng_ready=1). Expect the FSM in GRANT_L for 3 beats and a tag L pushed. The engine returns 3333 → l_level=3333, l_level_valid pulsed for exactly one cycle, r_level=0.
- Both valid at the same cycle: L sends 6666, 1111, 2222 and R sends 0000 x3. Expect L granted first and R granted after one IDLE cycle. Results 5555 then 0000 land in l_level and r_level in that order.
- Backpressure: drop eng_ready for 4 cycles after beat 2 of a left burst while r_valid=1. Expect l_ready=0 and the counter held, with no switch to R. The burst completes at beat 3 once eng_ready returns.
- Tag full: tag_depth=2, two sections granted, eng_res_valid held 0. Expect a third request to stay in IDLE with l_ready=r_ready=0. One result pop then allows the grant.
- Spurious result: eng_res_valid=1 with value 7777 while no sections are outstanding. Expect error to set and stay set, eng_res_ready=0, and both levels unchanged.
- Reset mid-burst: assert reset after 2 left beats. Expect immediate clear of all state and outputs. After release, a new left burst starts at beat 0 and L wins the first tie.
